// File: rtl/pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_reg_pkg
//   Shared constants and helpers for the pipe_reg register pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and number of stages.
//   clog2(value)                  : ceil(log2(value)), used to size the
//                                   occupancy counter (value >= 2 expected).
// ---------------------------------------------------------------------------
package pipe_reg_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One pipeline slot: a valid bit plus a WIDTH-bit data register.
//   Ports:
//     clock      rising-edge clock
//     reset      asynchronous active-low reset (clears valid and data)
//     flush_i    clears the valid bit; data is left untouched
//     advance_i  slot is allowed to change this cycle (its ready term)
//     valid_i    upstream word is valid
//     data_i     upstream word
//     valid_o    slot holds a valid word
//     data_o     held word
// ---------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             advance_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic             load;

    // When the slot may advance it either takes the upstream word or, with
    // nothing upstream, empties because its own word moved on.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        valid_d = valid_q;
        load    = 1'b0;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (advance_i) begin
            valid_d = valid_i;
            load    = valid_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            // NOTE: the data register is reset as well so out_data reads 0
            // during reset; plain storage arrays would normally skip this.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all stages updating from
            // the same pre-edge values, so words shift one slot per edge.
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_stage

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
//   DEPTH-stage valid/ready register pipeline with bubble collapse, flush
//   and an occupancy count.
//   Ports:
//     clock       rising-edge clock
//     reset       asynchronous active-low reset
//     in_valid    producer offers in_data
//     in_ready    pipeline accepts in_data this cycle
//     in_data     input word
//     out_valid   out_data holds a valid word (last stage)
//     out_ready   consumer takes out_data this cycle
//     out_data    output word (last stage)
//     flush       synchronous discard of all held words (beats transfers)
//     count       number of valid stages
// ---------------------------------------------------------------------------
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = clog2(DEPTH + 1);

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [WIDTH-1:0] src_data   [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             accept;
    logic             deliver;

    // Ready chain in closed form: ready[i] = out_ready OR some stage at or
    // after i is empty. This unrolls ready[i] = ready[i+1] | ~valid[i]
    // without building a combinational chain on one vector.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!stage_valid[j]) begin
                    ready[i] = 1'b1;
                end
            end
        end
    end

    // Each stage is fed by its predecessor; stage 0 by the input port.
    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = stage_valid[i-1];
            src_data[i]  = stage_data[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush_i  (flush),
            .advance_i(ready[g]),
            .valid_i  (src_valid[g]),
            .data_i   (src_data[g]),
            .valid_o  (stage_valid[g]),
            .data_o   (stage_data[g])
        );
    end

    assign in_ready  = ready[0] & ~flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    // Occupancy tracks handshakes; flush empties every stage at once.
    always_comb begin
        accept  = in_valid & in_ready;
        deliver = out_valid & out_ready;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !deliver) begin
            count_d = count_q + CW'(1);
        end else if (deliver && !accept) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg
//   Self-checking bench for pipe_reg (WIDTH=16, DEPTH=4). A reference model
//   keeps the held words as an ordered list of (stage position, data); each
//   edge the oldest word moves first, and every younger word advances only
//   if the slot ahead of it is free after the older words have moved.
// ---------------------------------------------------------------------------
module tb_pipe_reg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct {
        int               pos;
        logic [WIDTH-1:0] data;
    } word_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             flush = 1'b0;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_reg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .count    (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    word_t mq[$];
    word_t nq[$];
    word_t mw;
    int    barrier;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            nq.delete();
            // Position DEPTH stands for the consumer: free only if out_ready.
            barrier = out_ready ? DEPTH + 1 : DEPTH;
            foreach (mq[k]) begin
                mw = mq[k];
                if (mw.pos + 1 < barrier) mw.pos = mw.pos + 1;
                barrier = mw.pos;
                if (mw.pos < DEPTH) nq.push_back(mw);
            end
            if (in_valid && barrier > 0) begin
                mw.pos  = 0;
                mw.data = in_data;
                nq.push_back(mw);
            end
            mq = nq;
        end
    end

    // ---------------- compare process ----------------
    int   exp_cnt;
    logic exp_ov;
    logic exp_ir;

    always @(negedge clock) begin
        if (reset) begin
            exp_cnt = mq.size();
            exp_ov  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            exp_ir  = !flush && ((exp_cnt < DEPTH) || out_ready);
            check("model count", 64'(count), 64'(exp_cnt));
            check("model out_valid", 64'(out_valid), 64'(exp_ov));
            check("model in_ready", 64'(in_ready), 64'(exp_ir));
            if (exp_ov) check("model out_data", 64'(out_data), 64'(mq[0].data));
        end
    end

    // ---------------- directed stimulus ----------------
    int               w;
    int               acc;
    logic             hs;
    logic [WIDTH-1:0] got[$];

    initial begin
        // Reset held with random inputs.
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            #1;
            check("reset in_ready", 64'(in_ready), 64'(!flush));
            check("reset out_valid", 64'(out_valid), 64'(0));
            check("reset count", 64'(count), 64'(0));
            check("reset out_data", 64'(out_data), 64'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        reset     = 1'b1;
        #1;
        check("post-reset out_valid", 64'(out_valid), 64'(0));
        check("post-reset out_data", 64'(out_data), 64'(0));
        check("post-reset count", 64'(count), 64'(0));
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        // Latency: one word, out_ready high; visible after edge 3.
        tick();
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat edge0 out_valid", 64'(out_valid), 64'(0));
        check("lat edge0 count", 64'(count), 64'(1));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("lat out_valid", 64'(out_valid), 64'(k == 3));
        end
        check("lat out_data", 64'(out_data), 64'(16'hA5A5));
        check("lat count", 64'(count), 64'(1));
        tick();
        check("lat drained count", 64'(count), 64'(0));
        check("lat drained out_valid", 64'(out_valid), 64'(0));

        // Backpressure: producer holds each word until accepted.
        out_ready = 1'b0;
        w   = 1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(w);
            #1;
            hs = in_ready;
            tick();
            if (hs) begin
                acc++;
                w++;
            end
        end
        check("bp accepted", 64'(acc), 64'(4));
        check("bp in_ready", 64'(in_ready), 64'(0));
        check("bp count", 64'(count), 64'(4));
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            in_valid = (w <= 6);
            in_data  = 16'(w);
            #1;
            hs = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (hs) w++;
        end
        in_valid = 1'b0;
        check("bp delivered", 64'(got.size()), 64'(6));
        for (int k = 0; k < got.size(); k++) check("bp order", 64'(got[k]), 64'(k + 1));
        check("bp empty count", 64'(count), 64'(0));

        // Bubble collapse: words at cycles 0 and 5, stall from cycle 3.
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c == 0) || (c == 5);
            in_data   = (c == 0) ? 16'h1111 : 16'h2222;
            out_ready = (c < 3);
            tick();
        end
        in_valid = 1'b0;
        check("bubble count", 64'(count), 64'(2));
        check("bubble out_valid", 64'(out_valid), 64'(1));
        check("bubble out_data", 64'(out_data), 64'(16'h1111));
        check("bubble model size", 64'(mq.size()), 64'(2));
        if (mq.size() == 2) begin
            check("bubble model pos0", 64'(mq[0].pos), 64'(3));
            check("bubble model pos1", 64'(mq[1].pos), 64'(2));
        end
        out_ready = 1'b1;
        tick();
        check("bubble next out_data", 64'(out_data), 64'(16'h2222));
        check("bubble next count", 64'(count), 64'(1));
        tick();
        check("bubble drained", 64'(count), 64'(0));

        // Flush with three held words, a waiting input and out_ready high.
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = 16'h0C01 + 16'(c);
            tick();
        end
        in_valid = 1'b0;
        check("pre-flush count", 64'(count), 64'(3));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'(0));
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flush count", 64'(count), 64'(0));
        check("flush out_valid", 64'(out_valid), 64'(0));
        check("flush keeps data", 64'(out_data), 64'(16'h0C01));
        tick();
        tick();

        // Asynchronous reset between edges with three held words.
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = 16'h0D01 + 16'(c);
            tick();
        end
        in_valid = 1'b0;
        check("pre-areset count", 64'(count), 64'(3));
        check("pre-areset out_valid", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("areset out_valid", 64'(out_valid), 64'(0));
        check("areset count", 64'(count), 64'(0));
        check("areset out_data", 64'(out_data), 64'(0));
        tick();
        reset = 1'b1;
        tick();

        // Full-rate streaming with out_ready high.
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            tick();
        end
        check("stream count", 64'(count), 64'(DEPTH));
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("stream drained", 64'(count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_reg

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset: asserts immediately on low, releases synchronously to clock.
REQ-005 Port in_valid  input  1  producer offers in_data this cycle.
REQ-006 Port in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port in_data  input  WIDTH  input word.
REQ-008 Port out_valid  output  1  out_data holds a valid word.
REQ-009 Port out_ready  input  1  consumer takes out_data this cycle.
REQ-010 Port out_data  output  WIDTH  output word.
REQ-011 Port flush  input  1  synchronous discard of all held words.
REQ-012 Port count  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 Stages 0..DEPTH-1 each hold one valid bit and one WIDTH-bit data register; stage 0 is fed from the input side and stage DEPTH-1 drives out_valid/out_data directly.
REQ-014 Stage ready terms: ready[DEPTH-1] = out_ready OR NOT valid[DEPTH-1]; ready[i] = ready[i+1] OR NOT valid[i]; in_ready = ready[0] AND NOT flush.
REQ-015 Transfer rule: a word moves into stage i (from stage i-1, or from in_data for i=0) on an edge where the source is valid and ready[i] is high; empty stages collapse, so bubbles are never held behind a stall.
REQ-016 A stage whose word does not move SHALL keep its data unchanged; a data register loads only on a transfer into it.
REQ-017 Input handshake completes on an edge with in_valid AND in_ready; output handshake completes on an edge with out_valid AND out_ready.
REQ-018 Latency, empty pipe, no stall: a word accepted on edge t is presented with out_valid high after edge t+DEPTH-1; DEPTH=1 gives a single load register.
REQ-019 Throughput: with out_ready held high, one word per cycle is accepted and delivered in order, with no loss or duplication.
REQ-020 Full pipe (all valid) with out_ready low: in_ready is 0, all stages hold, and out_data is stable.
REQ-021 Full pipe with out_ready high: simultaneous accept and deliver on the same edge; count is unchanged.
REQ-022 flush high on an edge clears every valid bit; data registers keep their values; the input is not accepted that cycle; count is 0 after the edge.
REQ-023 flush has priority over all transfers on the same edge, including an out_ready handshake; a word presented at the output that cycle is treated as delivered only by the consumer's own view.
REQ-024 count SHALL equal the number of set valid bits after every edge: +1 on accept only, -1 on deliver only, unchanged on both or neither.
REQ-025 in_valid dropping while in_ready is low SHALL be permitted; the block relies on no producer hold-until-accept rule.

Reset
REQ-026 While reset is low: all valid bits = 0, all data registers = 0, out_valid = 0, out_data = 0, count = 0.
REQ-027 During reset, in_ready is high when flush is low (pipe empty), but no transfer occurs until reset is released.
REQ-028 Reset asserted mid-operation discards all held words immediately, independent of clock.

Structure
REQ-029 Package pipe_reg_pkg SHALL hold the default WIDTH/DEPTH constants and the count-width function clog2.
REQ-030 One sub-module, pipe_stage (valid bit + WIDTH-bit data register with load enable, async active-low reset), SHALL be instantiated DEPTH times via generate; the ready chain and count logic stay in pipe_reg.

Verification
REQ-031 Reset: hold reset low with random inputs, then release -> out_valid=0, out_data=0, count=0, in_ready=1.
REQ-032 Latency (DEPTH=4, WIDTH=16): single word 16'hA5A5 accepted at edge 0, out_ready=1 -> out_valid first high after edge 3, out_data=16'hA5A5, count returns to 0 after delivery edge.
REQ-033 Backpressure: out_ready=0, stream 16'h0001..16'h0006 -> exactly 4 accepted, in_ready=0, count=4; then out_ready=1 -> 0001..0006 delivered in order, none lost.
REQ-034 Bubble collapse: words at cycles 0 and 5, out_ready=0 from cycle 3 -> both words end in stages 3 and 2, count=2.
REQ-035 Flush: pipe holds 3 words, flush=1 with in_valid=1 and out_ready=1 -> after the edge count=0, out_valid=0, input word not accepted.
REQ-036 Async reset mid-stream: reset driven low between edges with count=3 -> out_valid and count drop to 0 before the next edge.
